core_mem_s: RTL and testbench
=============================

Name: core_mem_s

Overview:
Memory-access pipeline stage between execute and write-back (core_wb_s).
- Issues one load or store per instruction to the L1D over a req/ack handshake.
- Aligns load data so the byte or half sits in bits [7:0]/[15:0] for WB sign-extension.
- Registers all WB-bound fields.
- Stalls the upstream pipeline while an L1D transaction is outstanding.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for l1d_ack_in before aborting; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid_in  in  1  instruction present from EX
mem_op_in  in  2  MEM_OP_NONE=0, MEM_OP_LOAD=1, MEM_OP_STORE=2
mem_size_in  in  2  MEM_SZ_B=0, MEM_SZ_H=1, MEM_SZ_W=2
mem_alu_result_in  in  32  ALU result / effective address
mem_store_data_in  in  32  store data, right-justified
mem_pc_4_in  in  32  PC+4
mem_sx_op_in  in  3  WB extension select, forwarded
mem_sx_imm_in  in  32  immediate, forwarded
mem_mux_in  in  1  1 = ALU result, 0 = memory data (WB mux), forwarded
mem_we_reg_file_in  in  1  register-file write enable
l1d_req_out  out  1  L1D request
l1d_we_out  out  1  1 = store
l1d_addr_out  out  32  word-aligned address ([1:0]=0)
l1d_be_out  out  4  byte enables
l1d_wdata_out  out  32  lane-replicated store data
l1d_rdata_in  in  32  load data, valid with ack
l1d_ack_in  in  1  transaction complete
mem_stall_out  out  1  upstream must hold EX outputs
mem_err_out  out  1  one-cycle pulse: misalign or timeout
wb_valid_out  out  1  WB register holds a valid instruction
wb_alu_result_out  out  32  registered ALU result
wb_mem_data_out  out  32  registered, right-aligned load data
wb_pc_4_out  out  32  registered PC+4
wb_sx_op_out  out  3  registered sx_op
wb_sx_imm_out  out  32  registered immediate
wb_mux_out  out  1  registered mux select
wb_we_reg_file_out  out  1  registered write enable, gated by wb_valid_out

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low. All outputs and registers go to 0; state = IDLE.
- FSM has two states, IDLE and BUSY.
- IDLE, mem_valid_in=1, op=NONE:
  - Next edge: WB register loads the inputs, wb_valid_out=1.
  - Latency 1; no stall.
- IDLE, valid, LOAD/STORE, aligned:
  - Latch addr[31:2], offset addr[1:0], size, be and wdata, plus all WB fields.
  - Go to BUSY; wb_valid_out=0 on that edge.
- Alignment rules:
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned: no request; pulse mem_err_out; WB loads with wb_we_reg_file_out forced 0 and wb_valid_out=1; stay IDLE.
- Byte enables: B = 4'b0001 << off; H = 4'b0011 << off; W = 4'b1111.
- Store data lanes: B replicates [7:0]×4; H replicates [15:0]×2; W passes through.
- BUSY:
  - l1d_req_out=1, driven from a flop; address/be/we/wdata held stable.
  - mem_stall_out=1 (combinational, = state==BUSY).
  - EX inputs are ignored.
- l1d_ack_in=1 in BUSY:
  - Capture rdata >> (8*off) into wb_mem_data_out.
  - wb_valid_out=1; return to IDLE; req drops the next cycle.
  - Minimum load/store latency is 2 cycles: ack may arrive in the first BUSY cycle.
- l1d_ack_in in IDLE is ignored.
- Timeout: a counter increments each BUSY cycle without ack. On reaching ACK_TIMEOUT:
  - Deassert req; pulse mem_err_out.
  - Complete to WB with we forced 0; return to IDLE.
  - Counter clears on entry to BUSY.
- Bubbles: any edge that does not load the WB register (IDLE & !valid, BUSY without ack) sets wb_valid_out=0 and wb_we_reg_file_out=0. Other WB fields hold.
- Reset mid-transaction: req drops immediately. The L1D must tolerate an abandoned request; a late ack after reset is ignored.

Decomposition:
- core_pkg holds MEM_OP_*, MEM_SZ_* and the existing WB_SX_* constants.
- One sub-module, core_mem_align: combinational be/wdata generation, misalign detect and load right-shift. It can be tested standalone.
- FSM, timeout counter and WB register stay in core_mem_s.

Test Plan:
1. ALU op, valid, alu_result=0x1234_5678, we=1 -> next cycle wb_valid_out=1, wb_alu_result_out=0x1234_5678, wb_we=1, no req, stall 0.
2. LOAD B, addr=0x0000_1003, ack 3 cycles after req, rdata=0xAB00_0000 -> l1d_addr=0x0000_1000, be=4'b1000, stall high 3 cycles, wb_mem_data_out=0x0000_00AB.
3. STORE H, addr=0x0000_2002, data=0x0000_BEEF -> be=4'b1100, wdata=0xBEEF_BEEF, we=1, ack same first BUSY cycle -> total stall 1 cycle.
4. LOAD W addr=0x0000_3001 -> no req, mem_err_out pulse, wb_valid_out=1 with wb_we_reg_file_out=0.
5. ACK_TIMEOUT=4, load, never ack -> req high 4 cycles then low, mem_err_out pulse, wb_we=0, stall released.
6. rst_n low during BUSY -> l1d_req_out and stall 0 immediately. Ack after reset release ignored; next ALU op completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core's memory stage and write-back.
// The alignment helper lives here so the align block and any standalone user agree on it.
package core_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    localparam logic [2:0] WB_SX_NONE = 3'd0;
    localparam logic [2:0] WB_SX_B    = 3'd1;
    localparam logic [2:0] WB_SX_BU   = 3'd2;
    localparam logic [2:0] WB_SX_H    = 3'd3;
    localparam logic [2:0] WB_SX_HU   = 3'd4;
    localparam logic [2:0] WB_SX_IMM  = 3'd5;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Unshifted byte-enable footprint of an access size; unknown sizes act as word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_SZ_B: size_mask = 4'b0001;
            MEM_SZ_H: size_mask = 4'b0011;
            default:  size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/core_mem_align.sv
// Combinational L1D lane logic: byte enables, store replication, misalign
// detect and right-justification of load data.
module core_mem_align
    import core_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [1:0]  load_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    always_comb begin
        be        = (size == MEM_SZ_B || size == MEM_SZ_H) ? (size_mask(size) << off) : 4'b1111;
        load_data = rdata >> {load_off, 3'b000};
        case (size)
            MEM_SZ_B: begin
                wdata    = {4{store_data[7:0]}};
                misalign = 1'b0;
            end
            MEM_SZ_H: begin
                wdata    = {2{store_data[15:0]}};
                misalign = off[0];
            end
            default: begin
                wdata    = store_data;
                misalign = |off;
            end
        endcase
    end

endmodule

// File: rtl/core_mem_s.sv
// Memory stage: issues one L1D load/store per instruction, stalls EX while it
// is outstanding, and registers everything write-back needs.
module core_mem_s
    import core_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_in,
    input  logic [1:0]  mem_op_in,
    input  logic [1:0]  mem_size_in,
    input  logic [31:0] mem_alu_result_in,
    input  logic [31:0] mem_store_data_in,
    input  logic [31:0] mem_pc_4_in,
    input  logic [2:0]  mem_sx_op_in,
    input  logic [31:0] mem_sx_imm_in,
    input  logic        mem_mux_in,
    input  logic        mem_we_reg_file_in,
    output logic        l1d_req_out,
    output logic        l1d_we_out,
    output logic [31:0] l1d_addr_out,
    output logic [3:0]  l1d_be_out,
    output logic [31:0] l1d_wdata_out,
    input  logic [31:0] l1d_rdata_in,
    input  logic        l1d_ack_in,
    output logic        mem_stall_out,
    output logic        mem_err_out,
    output logic        wb_valid_out,
    output logic [31:0] wb_alu_result_out,
    output logic [31:0] wb_mem_data_out,
    output logic [31:0] wb_pc_4_out,
    output logic [2:0]  wb_sx_op_out,
    output logic [31:0] wb_sx_imm_out,
    output logic        wb_mux_out,
    output logic        wb_we_reg_file_out
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    mem_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    off;
    logic          we_hold;
    logic          busy, is_mem, start, bad, timeout, done;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, load_data;
    logic          misalign;

    core_mem_align u_align (
        .size       (mem_size_in),
        .off        (mem_alu_result_in[1:0]),
        .store_data (mem_store_data_in),
        .load_off   (off),
        .rdata      (l1d_rdata_in),
        .be         (be_c),
        .wdata      (wdata_c),
        .misalign   (misalign),
        .load_data  (load_data)
    );

    assign is_mem  = (mem_op_in == MEM_OP_LOAD) || (mem_op_in == MEM_OP_STORE);
    assign start   = !busy && mem_valid_in && is_mem && !misalign;
    assign bad     = !busy && mem_valid_in && is_mem && misalign;
    // Ack on the last allowed cycle still wins over the timeout.
    assign timeout = (ACK_TIMEOUT != 0) && busy && !l1d_ack_in && (cnt == TO_LAST);
    assign done    = busy && (l1d_ack_in || timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MEM_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE: if (start) state_nxt = MEM_BUSY;
            MEM_BUSY: if (done)  state_nxt = MEM_IDLE;
            default:             state_nxt = MEM_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == MEM_BUSY);
        mem_stall_out = busy;
    end

    // L1D request side and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1d_req_out   <= 1'b0;
            l1d_we_out    <= 1'b0;
            l1d_addr_out  <= '0;
            l1d_be_out    <= '0;
            l1d_wdata_out <= '0;
            off           <= '0;
            cnt           <= '0;
            mem_err_out   <= 1'b0;
        end else begin
            mem_err_out <= bad || timeout;
            if (start) begin
                l1d_req_out   <= 1'b1;
                l1d_we_out    <= (mem_op_in == MEM_OP_STORE);
                l1d_addr_out  <= {mem_alu_result_in[31:2], 2'b00};
                l1d_be_out    <= be_c;
                l1d_wdata_out <= wdata_c;
                off           <= mem_alu_result_in[1:0];
                cnt           <= '0;
            end else if (done) begin
                l1d_req_out <= 1'b0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Write-back register; any edge that does not complete an instruction is a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_out       <= 1'b0;
            wb_alu_result_out  <= '0;
            wb_mem_data_out    <= '0;
            wb_pc_4_out        <= '0;
            wb_sx_op_out       <= '0;
            wb_sx_imm_out      <= '0;
            wb_mux_out         <= 1'b0;
            wb_we_reg_file_out <= 1'b0;
            we_hold            <= 1'b0;
        end else begin
            wb_valid_out       <= 1'b0;
            wb_we_reg_file_out <= 1'b0;
            if (!busy && mem_valid_in) begin
                wb_alu_result_out <= mem_alu_result_in;
                wb_pc_4_out       <= mem_pc_4_in;
                wb_sx_op_out      <= mem_sx_op_in;
                wb_sx_imm_out     <= mem_sx_imm_in;
                wb_mux_out        <= mem_mux_in;
                if (start) begin
                    we_hold <= mem_we_reg_file_in;
                end else begin
                    wb_valid_out       <= 1'b1;
                    wb_we_reg_file_out <= mem_we_reg_file_in && !bad;
                end
            end else if (done) begin
                wb_valid_out       <= 1'b1;
                wb_we_reg_file_out <= we_hold && !timeout;
                wb_mem_data_out    <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_s.sv
// Self-checking bench for core_mem_s: directed vector table, random traffic
// against a byte-level reference model, and a mid-transaction reset sequence.
module tb_core_mem_s;
    import core_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic [1:0]  mem_op_in = '0;
    logic [1:0]  mem_size_in = '0;
    logic [31:0] mem_alu_result_in = '0;
    logic [31:0] mem_store_data_in = '0;
    logic [31:0] mem_pc_4_in = '0;
    logic [2:0]  mem_sx_op_in = '0;
    logic [31:0] mem_sx_imm_in = '0;
    logic        mem_mux_in = 1'b0;
    logic        mem_we_reg_file_in = 1'b0;
    logic        l1d_req_out, l1d_we_out;
    logic [31:0] l1d_addr_out, l1d_wdata_out;
    logic [3:0]  l1d_be_out;
    logic [31:0] l1d_rdata_in = '0;
    logic        l1d_ack_in = 1'b0;
    logic        mem_stall_out, mem_err_out, wb_valid_out;
    logic [31:0] wb_alu_result_out, wb_mem_data_out, wb_pc_4_out, wb_sx_imm_out;
    logic [2:0]  wb_sx_op_out;
    logic        wb_mux_out, wb_we_reg_file_out;

    int checks = 0;
    int errors = 0;

    core_mem_s #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_in(mem_valid_in), .mem_op_in(mem_op_in), .mem_size_in(mem_size_in),
        .mem_alu_result_in(mem_alu_result_in), .mem_store_data_in(mem_store_data_in),
        .mem_pc_4_in(mem_pc_4_in), .mem_sx_op_in(mem_sx_op_in), .mem_sx_imm_in(mem_sx_imm_in),
        .mem_mux_in(mem_mux_in), .mem_we_reg_file_in(mem_we_reg_file_in),
        .l1d_req_out(l1d_req_out), .l1d_we_out(l1d_we_out), .l1d_addr_out(l1d_addr_out),
        .l1d_be_out(l1d_be_out), .l1d_wdata_out(l1d_wdata_out), .l1d_rdata_in(l1d_rdata_in),
        .l1d_ack_in(l1d_ack_in), .mem_stall_out(mem_stall_out), .mem_err_out(mem_err_out),
        .wb_valid_out(wb_valid_out), .wb_alu_result_out(wb_alu_result_out),
        .wb_mem_data_out(wb_mem_data_out), .wb_pc_4_out(wb_pc_4_out),
        .wb_sx_op_out(wb_sx_op_out), .wb_sx_imm_out(wb_sx_imm_out), .wb_mux_out(wb_mux_out),
        .wb_we_reg_file_out(wb_we_reg_file_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;   // BUSY cycle carrying ack; <=0 means never
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        err;
        logic        mcheck;
        int          busy;    // expected stall cycles, 0 for no L1D access
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: derive lane behaviour byte by byte from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int nb = (v.sz == MEM_SZ_B) ? 1 : (v.sz == MEM_SZ_H) ? 2 : 4;
        int o  = int'(v.addr[1:0]);
        r.be = '0; r.wdata = '0; r.mdata = '0; r.err = 1'b0; r.mcheck = 1'b0; r.busy = 0;
        if (v.op == MEM_OP_LOAD || v.op == MEM_OP_STORE) begin
            if ((v.addr % nb) != 0) begin
                r.err = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    r.be[i] = (i >= o) && (i < o + nb);
                    r.wdata[8*i +: 8] = v.sdata[8*(i % nb) +: 8];
                    if (i + o < 4) r.mdata[8*i +: 8] = v.rdata[8*(i + o) +: 8];
                end
                if (v.delay < 1 || v.delay > TO) begin
                    r.err = 1'b1; r.busy = TO;
                end else begin
                    r.mcheck = 1'b1; r.busy = v.delay;
                end
            end
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [31:0] pc4 = $urandom;
        logic [31:0] imm = $urandom;
        logic [2:0]  sxo = 3'($urandom_range(0, 5));
        logic        mx  = 1'($urandom);
        int          c;
        mem_valid_in = 1'b1; mem_op_in = v.op; mem_size_in = v.sz;
        mem_alu_result_in = v.addr; mem_store_data_in = v.sdata;
        mem_pc_4_in = pc4; mem_sx_imm_in = imm; mem_sx_op_in = sxo; mem_mux_in = mx;
        mem_we_reg_file_in = v.we;
        tick();
        if (v.busy == 0) begin
            mem_valid_in = 1'b0;
            chk("direct_valid", {31'd0, wb_valid_out}, 32'd1);
            chk("direct_req", {31'd0, l1d_req_out}, 32'd0);
            chk("direct_stall", {31'd0, mem_stall_out}, 32'd0);
            chk("direct_err", {31'd0, mem_err_out}, {31'd0, v.err});
            chk("direct_we", {31'd0, wb_we_reg_file_out}, {31'd0, v.we & ~v.err});
        end else begin
            // Junk on EX inputs during BUSY must be ignored.
            mem_op_in = MEM_OP_NONE; mem_alu_result_in = ~v.addr; mem_pc_4_in = ~pc4;
            chk("issue_valid", {31'd0, wb_valid_out}, 32'd0);
            chk("issue_we_l1d", {31'd0, l1d_we_out}, {31'd0, v.op == MEM_OP_STORE});
            chk("issue_wdata", l1d_wdata_out, v.wdata);
            c = 0;
            while (1) begin
                c++;
                chk("busy_req", {31'd0, l1d_req_out}, 32'd1);
                chk("busy_addr_be", {l1d_addr_out[31:4], l1d_be_out}, {v.addr[31:4], v.be});
                chk("busy_addr_lo", {30'd0, l1d_addr_out[3:2], l1d_addr_out[1:0]},
                    {30'd0, v.addr[3:2], 2'b00});
                l1d_ack_in   = (c == v.delay);
                l1d_rdata_in = l1d_ack_in ? v.rdata : $urandom;
                tick();
                l1d_ack_in = 1'b0;
                if (!mem_stall_out) break;
                if (c >= 20) begin
                    chk("busy_bound", 32'(c), 32'(v.busy));
                    break;
                end
            end
            mem_valid_in = 1'b0;
            chk("stall_cycles", 32'(c), 32'(v.busy));
            chk("done_valid", {31'd0, wb_valid_out}, 32'd1);
            chk("done_req", {31'd0, l1d_req_out}, 32'd0);
            chk("done_err", {31'd0, mem_err_out}, {31'd0, v.err});
            chk("done_we", {31'd0, wb_we_reg_file_out}, {31'd0, v.we & ~v.err});
            if (v.mcheck) chk("mem_data", wb_mem_data_out, v.mdata);
        end
        chk("wb_alu", wb_alu_result_out, v.addr);
        chk("wb_pc4", wb_pc_4_out, pc4);
        chk("wb_misc", {wb_sx_imm_out[27:0], wb_sx_op_out, wb_mux_out}, {imm[27:0], sxo, mx});
        tick();
        chk("bubble", {29'd0, wb_valid_out, wb_we_reg_file_out, mem_err_out}, 32'd0);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        tbl[0]  = '{MEM_OP_NONE,  MEM_SZ_W, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b1,
                    4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        tbl[1]  = '{MEM_OP_LOAD,  MEM_SZ_B, 32'h0000_1003, 32'h0, 32'hAB00_0000, 3, 1'b1,
                    4'b1000, 32'h0, 32'h0000_00AB, 1'b0, 1'b1, 3};
        tbl[2]  = '{MEM_OP_STORE, MEM_SZ_H, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1, 1'b0,
                    4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b1, 1};
        tbl[3]  = '{MEM_OP_LOAD,  MEM_SZ_W, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b1,
                    4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0};
        tbl[4]  = '{MEM_OP_LOAD,  MEM_SZ_W, 32'h0000_4000, 32'h0, 32'hDEAD_0001, -1, 1'b1,
                    4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 4};
        tbl[5]  = '{MEM_OP_LOAD,  MEM_SZ_H, 32'h0000_0006, 32'h0, 32'hCAFE_1234, 2, 1'b1,
                    4'b1100, 32'h0, 32'h0000_CAFE, 1'b0, 1'b1, 2};
        tbl[6]  = '{MEM_OP_STORE, MEM_SZ_B, 32'h0000_0001, 32'h1234_56A5, 32'h0, 1, 1'b0,
                    4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1, 1};
        tbl[7]  = '{MEM_OP_STORE, MEM_SZ_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2, 1'b0,
                    4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 2};
        tbl[8]  = '{MEM_OP_LOAD,  MEM_SZ_H, 32'h0000_0003, 32'h0, 32'h0, 0, 1'b1,
                    4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0};
        tbl[9]  = '{MEM_OP_LOAD,  MEM_SZ_B, 32'h0000_0000, 32'h0, 32'h1122_3344, 4, 1'b1,
                    4'b0001, 32'h0, 32'h1122_3344, 1'b0, 1'b1, 4};
        tbl[10] = '{MEM_OP_LOAD,  MEM_SZ_B, 32'h0000_0002, 32'h0, 32'h1122_3344, 5, 1'b1,
                    4'b0100, 32'h0, 32'h0, 1'b1, 1'b0, 4};

        tick(); tick();
        chk("reset_ctl", {28'd0, l1d_req_out, mem_stall_out, wb_valid_out, mem_err_out}, 32'd0);
        chk("reset_wb", wb_alu_result_out | wb_pc_4_out | l1d_addr_out, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            rv.op    = 2'($urandom_range(0, 2));
            rv.sz    = 2'($urandom_range(0, 2));
            rv.addr  = $urandom;
            rv.sdata = $urandom;
            rv.rdata = $urandom;
            rv.delay = $urandom_range(1, TO + 2);
            rv.we    = 1'($urandom);
            run_txn(model(rv));
        end

        // Reset while a load is outstanding, then a stray ack in IDLE.
        mem_valid_in = 1'b1; mem_op_in = MEM_OP_LOAD; mem_size_in = MEM_SZ_W;
        mem_alu_result_in = 32'h0000_0100; mem_we_reg_file_in = 1'b1;
        tick();
        mem_valid_in = 1'b0;
        chk("pre_rst_stall", {31'd0, mem_stall_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", {30'd0, l1d_req_out, mem_stall_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        l1d_ack_in = 1'b1; l1d_rdata_in = 32'h5A5A_5A5A;
        tick();
        l1d_ack_in = 1'b0;
        chk("late_ack", {28'd0, wb_valid_out, l1d_req_out, mem_stall_out, mem_err_out}, 32'd0);
        run_txn(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
